// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// instruction fields, ALU function codes and datapath mux selects.
package mips_ctrl_pkg;

    localparam int STATE_BITS = 4;
    localparam int ALU_BITS   = 4;

    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_RWB    = 4'd7,
        S_EXEC_I = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // ALU function codes; ADD is zero so idle states present a harmless add
    localparam logic [ALU_BITS-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_BITS-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_BITS-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_BITS-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_BITS-1:0] ALU_SLT = 4'd4;
    localparam logic [ALU_BITS-1:0] ALU_SLL = 4'd5;
    localparam logic [ALU_BITS-1:0] ALU_LUI = 4'd6;

    // Register-file destination select
    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    // Register-file write-data select
    localparam logic [1:0] WD_ALUOUT = 2'd0;
    localparam logic [1:0] WD_MDR    = 2'd1;
    localparam logic [1:0] WD_PC     = 2'd2;

    // ALU operand B select
    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    // Next-PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_REG    = 2'd3;

    // Immediate extension mode
    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    // R-type functions that go through EXEC_R (jr has its own state)
    function automatic logic is_rtype_alu_funct(input logic [5:0] funct);
        case (funct)
            FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLL: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU/extender decode for the execute states: R-type uses funct,
// I-type ALU instructions use the opcode.
module mc_alu_dec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    output logic [ALU_BITS-1:0] alu_op,
    output logic [1:0]          ext_op
);

    // Pure combinational decode; unknown codes fall back to add/sign-extend
    always_comb begin
        alu_op = ALU_ADD;
        ext_op = EXT_SIGN;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADDU: alu_op = ALU_ADD;
                FN_SUBU: alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_SLT:  alu_op = ALU_SLT;
                FN_SLL:  alu_op = ALU_SLL;
                default: alu_op = ALU_ADD;
            endcase
        end else begin
            case (opcode)
                OP_ORI: begin
                    alu_op = ALU_OR;
                    ext_op = EXT_ZERO;
                end
                OP_LUI: begin
                    alu_op = ALU_LUI;
                    ext_op = EXT_LUI;
                end
                OP_SLTI: alu_op = ALU_SLT;
                default: alu_op = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: Moore FSM stepping each instruction
// through fetch, decode, execute, memory and write-back.
module mc_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_W = 4,
    parameter int ST_W  = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_wr,
    output logic             pc_wr_cond,
    output logic             ir_wr,
    output logic             reg_wr,
    output logic             mem_wr,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       ext_op,
    output logic [ALU_W-1:0] alu_op,
    output logic [1:0]       pc_src,
    output logic             illegal,
    output logic [ST_W-1:0]  dbg_state
);

    state_t              state_reg;
    state_t              state_next;
    logic [ALU_BITS-1:0] alu_code;
    logic [ALU_BITS-1:0] dec_alu_op;
    logic [1:0]          dec_ext_op;
    logic                unused_zero;

    // The branch decision is made by the datapath gating pc_wr_cond with
    // zero, so the FSM itself never needs the flag.
    assign unused_zero = zero;

    mc_alu_dec u_alu_dec (
        .opcode (opcode),
        .funct  (funct),
        .alu_op (dec_alu_op),
        .ext_op (dec_ext_op)
    );

    assign alu_op    = ALU_W'(alu_code);
    assign dbg_state = ST_W'(state_reg);

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and per-state datapath controls
    always_comb begin
        state_next = S_FETCH;
        pc_wr      = 1'b0;
        pc_wr_cond = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        reg_dst    = REG_DST_RT;
        wd_sel     = WD_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        ext_op     = EXT_ZERO;
        alu_code   = ALU_ADD;
        pc_src     = PC_SRC_ALU;
        illegal    = 1'b0;

        case (state_reg)
            S_FETCH: begin
                ir_wr      = 1'b1;
                pc_wr      = 1'b1;
                alu_src_b  = SRCB_FOUR;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut <= PC+4 + (sext(imm) << 2): branch target ready for BRANCH
                alu_src_b = SRCB_IMM_SH2;
                ext_op    = EXT_SIGN;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            state_next = S_JR;
                        end else if (is_rtype_alu_funct(funct)) begin
                            state_next = S_EXEC_R;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    OP_BEQ: state_next = S_BRANCH;
                    OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI, OP_SLTI: state_next = S_EXEC_I;
                    OP_J:   state_next = S_JUMP;
                    OP_JAL: state_next = S_JAL;
                    default: illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ext_op    = EXT_SIGN;
                if (opcode == OP_LW) begin
                    state_next = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    state_next = S_MEMWR;
                end
            end
            S_MEMRD: begin
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                reg_wr  = 1'b1;
                reg_dst = REG_DST_RT;
                wd_sel  = WD_MDR;
            end
            S_MEMWR: begin
                mem_wr = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_B;
                alu_code   = dec_alu_op;
                state_next = S_RWB;
            end
            S_RWB: begin
                reg_wr  = 1'b1;
                reg_dst = REG_DST_RD;
                wd_sel  = WD_ALUOUT;
            end
            S_EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                ext_op     = dec_ext_op;
                alu_code   = dec_alu_op;
                state_next = S_IWB;
            end
            S_IWB: begin
                reg_wr  = 1'b1;
                reg_dst = REG_DST_RT;
                wd_sel  = WD_ALUOUT;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_B;
                alu_code   = ALU_SUB;
                pc_wr_cond = 1'b1;
                pc_src     = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                pc_wr  = 1'b1;
                pc_src = PC_SRC_JUMP;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value
                pc_wr   = 1'b1;
                pc_src  = PC_SRC_JUMP;
                reg_wr  = 1'b1;
                reg_dst = REG_DST_RA;
                wd_sel  = WD_PC;
            end
            S_JR: begin
                pc_wr  = 1'b1;
                pc_src = PC_SRC_REG;
            end
            default: state_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed per-cycle table, reset
// corner cases, then random instruction streams against an
// instruction-level model.
module tb_mc_ctrl_fsm;
    import mips_ctrl_pkg::*;

    logic       clock = 1'b1;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_wr, pc_wr_cond, ir_wr, reg_wr, mem_wr, alu_src_a, illegal;
    logic [1:0] reg_dst, wd_sel, alu_src_b, ext_op, pc_src;
    logic [3:0] alu_op;
    logic [3:0] dbg_state;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       pcwc;
        logic       irw;
        logic       rw;
        logic       mw;
        logic [1:0] rd;
        logic [1:0] wd;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] eo;
        logic [3:0] ao;
        logic [1:0] ps;
        logic       ill;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       zr;
        outs_t      exp;
        logic       pl;
    } vec_t;

    outs_t act;
    logic  act_pl;
    outs_t exp_q[$];
    vec_t  tbl[$];
    int    n_vec = 0;
    int    n_bad = 0;

    mc_ctrl_fsm #(.ALU_W(4), .ST_W(4)) dut (
        .clock      (clock),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .pc_wr      (pc_wr),
        .pc_wr_cond (pc_wr_cond),
        .ir_wr      (ir_wr),
        .reg_wr     (reg_wr),
        .mem_wr     (mem_wr),
        .reg_dst    (reg_dst),
        .wd_sel     (wd_sel),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_op     (ext_op),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .illegal    (illegal),
        .dbg_state  (dbg_state)
    );

    // Posedges at 10,20,30...; negedges at 5,15,25... (reset releases on one)
    always #5 clock = ~clock;

    always_comb begin
        act    = {dbg_state, pc_wr, pc_wr_cond, ir_wr, reg_wr, mem_wr, reg_dst,
                  wd_sel, alu_src_a, alu_src_b, ext_op, alu_op, pc_src, illegal};
        // PC load as the datapath would see it
        act_pl = pc_wr | (pc_wr_cond & zero);
    end

    function automatic outs_t o(input logic [3:0] st, input logic pcw, input logic pcwc,
                                input logic irw, input logic rw, input logic mw,
                                input logic [1:0] rd, input logic [1:0] wd, input logic sa,
                                input logic [1:0] sb, input logic [1:0] eo,
                                input logic [3:0] ao, input logic [1:0] ps, input logic ill);
        return {st, pcw, pcwc, irw, rw, mw, rd, wd, sa, sb, eo, ao, ps, ill};
    endfunction

    function automatic vec_t v(input logic [5:0] op, input logic [5:0] fn, input logic zr,
                               input outs_t exp, input logic pl);
        vec_t r;
        r.op = op; r.fn = fn; r.zr = zr; r.exp = exp; r.pl = pl;
        return r;
    endfunction

    task automatic chk(input string name, input outs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h (state %0d) want %h (state %0d)",
                     name, act, act.st, exp, exp.st);
        end
    endtask

    task automatic chk_pl(input string name, input logic exp);
        n_vec++;
        if (act_pl !== exp) begin
            n_bad++;
            $display("FAIL %s pc_load: got %b want %b", name, act_pl, exp);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h23, 6'h2B, 6'h04, 6'h08, 6'h09, 6'h0D, 6'h0F, 6'h0A, 6'h02, 6'h03: return 1'b1;
            6'h00: return fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h08};
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h23:   return ALU_SUB;
            6'h24:   return ALU_AND;
            6'h25:   return ALU_OR;
            6'h2A:   return ALU_SLT;
            6'h00:   return ALU_SLL;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [3:0] i_alu(input logic [5:0] op);
        case (op)
            6'h0D:   return ALU_OR;
            6'h0F:   return ALU_LUI;
            6'h0A:   return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [1:0] i_ext(input logic [5:0] op);
        if (op == 6'h0D) return 2'd0;
        if (op == 6'h0F) return 2'd2;
        return 2'd1;
    endfunction

    // Expected per-cycle outputs for one instruction, FETCH included
    function automatic void model(input logic [5:0] op, input logic [5:0] fn);
        exp_q.delete();
        exp_q.push_back(o(S_FETCH, 1,0,1,0,0, 0,0, 0,1,0, ALU_ADD, 0, 0));
        if (!legal(op, fn)) begin
            exp_q.push_back(o(S_DECODE, 0,0,0,0,0, 0,0, 0,3,1, ALU_ADD, 0, 1));
            return;
        end
        exp_q.push_back(o(S_DECODE, 0,0,0,0,0, 0,0, 0,3,1, ALU_ADD, 0, 0));
        case (op)
            6'h23: begin
                exp_q.push_back(o(S_MEMADR, 0,0,0,0,0, 0,0, 1,2,1, ALU_ADD, 0, 0));
                exp_q.push_back(o(S_MEMRD,  0,0,0,0,0, 0,0, 0,0,0, ALU_ADD, 0, 0));
                exp_q.push_back(o(S_MEMWB,  0,0,0,1,0, 0,1, 0,0,0, ALU_ADD, 0, 0));
            end
            6'h2B: begin
                exp_q.push_back(o(S_MEMADR, 0,0,0,0,0, 0,0, 1,2,1, ALU_ADD, 0, 0));
                exp_q.push_back(o(S_MEMWR,  0,0,0,0,1, 0,0, 0,0,0, ALU_ADD, 0, 0));
            end
            6'h00: begin
                if (fn == 6'h08) begin
                    exp_q.push_back(o(S_JR, 1,0,0,0,0, 0,0, 0,0,0, ALU_ADD, 3, 0));
                end else begin
                    exp_q.push_back(o(S_EXEC_R, 0,0,0,0,0, 0,0, 1,0,0, r_alu(fn), 0, 0));
                    exp_q.push_back(o(S_RWB,    0,0,0,1,0, 1,0, 0,0,0, ALU_ADD, 0, 0));
                end
            end
            6'h04: exp_q.push_back(o(S_BRANCH, 0,1,0,0,0, 0,0, 1,0,0, ALU_SUB, 1, 0));
            6'h02: exp_q.push_back(o(S_JUMP,   1,0,0,0,0, 0,0, 0,0,0, ALU_ADD, 2, 0));
            6'h03: exp_q.push_back(o(S_JAL,    1,0,0,1,0, 2,2, 0,0,0, ALU_ADD, 2, 0));
            default: begin
                exp_q.push_back(o(S_EXEC_I, 0,0,0,0,0, 0,0, 1,2,i_ext(op), i_alu(op), 0, 0));
                exp_q.push_back(o(S_IWB,    0,0,0,1,0, 0,0, 0,0,0, ALU_ADD, 0, 0));
            end
        endcase
    endfunction

    // Entered on a negedge with the DUT in FETCH; leaves it the same way
    task automatic run_instr(input int idx, input logic [5:0] op, input logic [5:0] fn,
                             input logic zr);
        model(op, fn);
        opcode = op;
        funct  = fn;
        zero   = zr;
        for (int k = 0; k < exp_q.size(); k++) begin
            #1;
            chk($sformatf("rand%0d op=%h fn=%h cyc%0d", idx, op, fn, k), exp_q[k]);
            @(negedge clock);
        end
    endtask

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        outs_t F, D, DI, MA, MR, MWB, MW, ERA, RWB, JRS, BR, JALS, EIL, IWB;
        logic [5:0] ops[11];
        logic [5:0] fns[7];
        logic [5:0] op, fn;

        F    = o(S_FETCH,  1,0,1,0,0, 0,0, 0,1,0, ALU_ADD, 0, 0);
        D    = o(S_DECODE, 0,0,0,0,0, 0,0, 0,3,1, ALU_ADD, 0, 0);
        DI   = o(S_DECODE, 0,0,0,0,0, 0,0, 0,3,1, ALU_ADD, 0, 1);
        MA   = o(S_MEMADR, 0,0,0,0,0, 0,0, 1,2,1, ALU_ADD, 0, 0);
        MR   = o(S_MEMRD,  0,0,0,0,0, 0,0, 0,0,0, ALU_ADD, 0, 0);
        MWB  = o(S_MEMWB,  0,0,0,1,0, 0,1, 0,0,0, ALU_ADD, 0, 0);
        MW   = o(S_MEMWR,  0,0,0,0,1, 0,0, 0,0,0, ALU_ADD, 0, 0);
        ERA  = o(S_EXEC_R, 0,0,0,0,0, 0,0, 1,0,0, ALU_ADD, 0, 0);
        RWB  = o(S_RWB,    0,0,0,1,0, 1,0, 0,0,0, ALU_ADD, 0, 0);
        JRS  = o(S_JR,     1,0,0,0,0, 0,0, 0,0,0, ALU_ADD, 3, 0);
        BR   = o(S_BRANCH, 0,1,0,0,0, 0,0, 1,0,0, ALU_SUB, 1, 0);
        JALS = o(S_JAL,    1,0,0,1,0, 2,2, 0,0,0, ALU_ADD, 2, 0);
        EIL  = o(S_EXEC_I, 0,0,0,0,0, 0,0, 1,2,2, ALU_LUI, 0, 0);
        IWB  = o(S_IWB,    0,0,0,1,0, 0,0, 0,0,0, ALU_ADD, 0, 0);

        // Per-cycle directed walk: {opcode, funct, zero, outputs, pc load}
        // lw: 5 cycles, write-back from MDR only in the last one
        tbl.push_back(v(6'h23, 6'h00, 0, F,   1));
        tbl.push_back(v(6'h23, 6'h00, 0, D,   0));
        tbl.push_back(v(6'h23, 6'h00, 0, MA,  0));
        tbl.push_back(v(6'h23, 6'h00, 0, MR,  0));
        tbl.push_back(v(6'h23, 6'h00, 0, MWB, 0));
        // addu: 4 cycles
        tbl.push_back(v(6'h00, 6'h21, 0, F,   1));
        tbl.push_back(v(6'h00, 6'h21, 0, D,   0));
        tbl.push_back(v(6'h00, 6'h21, 0, ERA, 0));
        tbl.push_back(v(6'h00, 6'h21, 0, RWB, 0));
        // jr: 3 cycles
        tbl.push_back(v(6'h00, 6'h08, 0, F,   1));
        tbl.push_back(v(6'h00, 6'h08, 0, D,   0));
        tbl.push_back(v(6'h00, 6'h08, 0, JRS, 1));
        // beq taken, then not taken
        tbl.push_back(v(6'h04, 6'h00, 1, F,   1));
        tbl.push_back(v(6'h04, 6'h00, 1, D,   0));
        tbl.push_back(v(6'h04, 6'h00, 1, BR,  1));
        tbl.push_back(v(6'h04, 6'h00, 0, F,   1));
        tbl.push_back(v(6'h04, 6'h00, 0, D,   0));
        tbl.push_back(v(6'h04, 6'h00, 0, BR,  0));
        // jal
        tbl.push_back(v(6'h03, 6'h00, 0, F,    1));
        tbl.push_back(v(6'h03, 6'h00, 0, D,    0));
        tbl.push_back(v(6'h03, 6'h00, 0, JALS, 1));
        // lui: ext_op=2 in EXEC_I
        tbl.push_back(v(6'h0F, 6'h00, 0, F,   1));
        tbl.push_back(v(6'h0F, 6'h00, 0, D,   0));
        tbl.push_back(v(6'h0F, 6'h00, 0, EIL, 0));
        tbl.push_back(v(6'h0F, 6'h00, 0, IWB, 0));
        // unsupported opcode, then unsupported funct: illegal in DECODE
        tbl.push_back(v(6'h3F, 6'h00, 0, F,  1));
        tbl.push_back(v(6'h3F, 6'h00, 0, DI, 0));
        tbl.push_back(v(6'h00, 6'h3F, 0, F,  1));
        tbl.push_back(v(6'h00, 6'h3F, 0, DI, 0));
        // sw: 4 cycles, mem_wr only in the last
        tbl.push_back(v(6'h2B, 6'h00, 0, F,  1));
        tbl.push_back(v(6'h2B, 6'h00, 0, D,  0));
        tbl.push_back(v(6'h2B, 6'h00, 0, MA, 0));
        tbl.push_back(v(6'h2B, 6'h00, 0, MW, 0));

        // Reset pulse of 25 ns with random junk on the inputs
        rst    = 1'b1;
        opcode = 6'h23;
        funct  = 6'h21;
        zero   = 1'b1;
        #12;
        chk("reset_a", F);
        #10;
        chk("reset_b", F);
        #3;
        rst = 1'b0;   // t=25, a negedge

        for (int i = 0; i < tbl.size(); i++) begin
            opcode = tbl[i].op;
            funct  = tbl[i].fn;
            zero   = tbl[i].zr;
            #1;
            chk($sformatf("tbl%0d", i), tbl[i].exp);
            chk_pl($sformatf("tbl%0d", i), tbl[i].pl);
            @(negedge clock);
        end

        // Reset asserted during MEMRD of a lw: immediate FETCH, no write-back
        opcode = 6'h23;
        funct  = 6'h00;
        zero   = 1'b0;
        #1 chk("rstmid_fetch", F);
        @(negedge clock);
        #1 chk("rstmid_decode", D);
        @(negedge clock);
        #1 chk("rstmid_memadr", MA);
        @(negedge clock);
        #1 chk("rstmid_memrd", MR);
        #2 rst = 1'b1;
        #1 chk("rstmid_async", F);
        @(negedge clock);
        chk("rstmid_hold", F);
        rst = 1'b0;

        // Random instruction stream against the model
        ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h09, 6'h0D, 6'h0F, 6'h0A, 6'h02, 6'h03};
        fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h08};
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 15) < 12) op = ops[$urandom_range(0, 10)];
            else                            op = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) < 6)   fn = fns[$urandom_range(0, 6)];
            else                            fn = 6'($urandom_range(0, 63));
            run_instr(i, op, fn, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
